spi_stimulus_multichannel: RTL and testbench

Next-generation SPI stimulus generator. It drives one of `channel_count` slave-select lines and a shared serial clock for a runtime-selectable number of bits. The SCLK rate is set by a parameterised divider, and per-edge shift/sample strobes are provided for CPHA-aware transmitters and receivers. It sits between a transfer controller (trigger, channel, bitcount) and the SPI shift registers / pins.

---
 rtl/spi_stimulus_multichannel_pkg.sv | 32 +++
 rtl/spi_clock_divider.sv | 44 ++++
 rtl/spi_stimulus_multichannel.sv | 259 +++++++++++++++++++++++++
 tb/tb_spi_stimulus_multichannel.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_stimulus_multichannel_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_stimulus_multichannel_pkg: shared SPI sequencer states, modes, utils |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package spi_stimulus_multichannel_pkg;

  localparam logic [2:0] STATE_IDLE  = 3'd0;
  localparam logic [2:0] STATE_LEAD  = 3'd1;
  localparam logic [2:0] STATE_CLOCK = 3'd2;
  localparam logic [2:0] STATE_TRAIL = 3'd3;
  localparam logic [2:0] STATE_DONE  = 3'd4;

  // Mode constants shared with the transmitter and receiver shift registers.
  localparam bit CPOL_IDLE_LOW        = 1'b0;
  localparam bit CPOL_IDLE_HIGH       = 1'b1;
  localparam bit CPHA_SAMPLE_LEADING  = 1'b0;
  localparam bit CPHA_SAMPLE_TRAILING = 1'b1;

  // Width of a counter holding 0..value-1, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    return (value < 2) ? 1 : $clog2(value);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clock_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_clock_divider: one-tick half-period pulse every `divider` ticks      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_clock_divider
  import spi_stimulus_multichannel_pkg::*;
#(
  parameter int divider = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  output logic half_period
);

  localparam int CNT_W = clog2_min1(divider);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(divider - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             w_pulse;

  assign w_pulse     = enable && (cnt_q == c_last);
  assign half_period = w_pulse;

  // Counter is held at zero whenever disabled so every run starts aligned.
  always_comb begin
    cnt_d = '0;
    if (enable && !w_pulse) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_stimulus_multichannel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_stimulus_multichannel: SS/SCLK/strobe sequencer for N-bit transfers  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_stimulus_multichannel
  import spi_stimulus_multichannel_pkg::*;
#(
  parameter int channel_count                      = 4,
  parameter int max_bitcount                       = 32,
  parameter int clock_divider                      = 2,
  parameter bit ss_polarity                        = 1'b0,
  parameter bit sclk_polarity                      = 1'b0,
  parameter bit sclk_phase                         = 1'b0,
  parameter int tick_count_sclk_delay_leading      = 0,
  parameter int tick_count_sclk_delay_trailing     = 0,
  parameter int tick_count_complete_delay_trailing = 0
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  trigger,
  input  logic [clog2_min1(channel_count)-1:0]  channel,
  input  logic [$clog2(max_bitcount+1)-1:0]     bitcount,
  input  logic                                  abort,
  input  logic                                  invalidate,
  output logic [channel_count-1:0]              ss,
  output logic                                  sclk,
  output logic                                  shift_strobe,
  output logic                                  sample_strobe,
  output logic                                  busy,
  output logic                                  complete,
  output logic                                  aborted,
  output logic                                  valid
);

  localparam int CC  = channel_count;
  localparam int CW  = clog2_min1(channel_count);
  localparam int CW1 = CW + 1;
  localparam int BW  = $clog2(max_bitcount + 1);
  localparam int EW  = $clog2(2 * max_bitcount + 1);
  localparam int DW  = clog2_min1(max3(tick_count_sclk_delay_leading,
                                       tick_count_sclk_delay_trailing,
                                       tick_count_complete_delay_trailing));

  localparam logic [CC-1:0]  c_ss_idle   = {CC{!ss_polarity}};
  localparam logic [CC-1:0]  c_ss_one    = CC'(1);
  localparam logic [CW1-1:0] c_chan_cnt  = CW1'(channel_count);
  localparam logic [BW-1:0]  c_max_bc    = BW'(max_bitcount);
  localparam logic [DW-1:0]  c_lead_last =
    DW'((tick_count_sclk_delay_leading > 0) ? tick_count_sclk_delay_leading - 1 : 0);
  localparam logic [DW-1:0]  c_trail_last =
    DW'((tick_count_sclk_delay_trailing > 0) ? tick_count_sclk_delay_trailing - 1 : 0);
  localparam logic [DW-1:0]  c_done_last =
    DW'((tick_count_complete_delay_trailing > 0) ? tick_count_complete_delay_trailing - 1 : 0);

  logic [2:0]    state_q,     state_d;
  logic          trig_prev_q, trig_prev_d;
  logic [CC-1:0] ss_q,        ss_d;
  logic          sclk_q,      sclk_d;
  logic          shift_q,     shift_d;
  logic          sample_q,    sample_d;
  logic          busy_q,      busy_d;
  logic          complete_q,  complete_d;
  logic          aborted_q,   aborted_d;
  logic          valid_q,     valid_d;
  logic [BW-1:0] n_q,         n_d;
  logic [EW-1:0] edge_q,      edge_d;
  logic [DW-1:0] dly_q,       dly_d;

  logic          w_half;
  logic          w_div_en;
  logic          w_trig_edge;
  logic          w_chan_ok;
  logic          w_start;
  logic          w_leading;
  logic          w_valid_live;
  logic          w_release;
  logic [BW-1:0] w_eff_n;
  logic [EW-1:0] w_two_n;
  logic [EW-1:0] w_two_n_m1;
  logic [CC-1:0] w_sel_ss;

  assign w_div_en     = (state_q == STATE_CLOCK);
  assign w_trig_edge  = trigger && !trig_prev_q;
  assign w_chan_ok    = ({1'b0, channel} < c_chan_cnt);
  assign w_start      = w_trig_edge && !busy_q && w_chan_ok;
  assign w_eff_n      = ((bitcount == '0) || (bitcount > c_max_bc)) ? c_max_bc : bitcount;
  assign w_sel_ss     = c_ss_idle ^ (c_ss_one << channel);
  assign w_two_n      = EW'({n_q, 1'b0});
  assign w_two_n_m1   = w_two_n - 1'b1;
  // Even edge count means the next edge moves SCLK away from its idle level.
  assign w_leading    = !edge_q[0];
  assign w_valid_live = valid_q && !invalidate;

  spi_clock_divider #(
    .divider (clock_divider)
  ) u_divider (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (w_div_en),
    .half_period (w_half)
  );

  always_comb begin
    state_d     = state_q;
    trig_prev_d = trigger;
    ss_d        = ss_q;
    sclk_d      = sclk_q;
    shift_d     = 1'b0;
    sample_d    = 1'b0;
    busy_d      = busy_q;
    complete_d  = complete_q;
    aborted_d   = aborted_q;
    valid_d     = valid_q;
    n_d         = n_q;
    edge_d      = edge_q;
    dly_d       = dly_q;
    w_release   = 1'b0;

    if (abort) begin
      state_d    = STATE_IDLE;
      ss_d       = c_ss_idle;
      sclk_d     = sclk_polarity;
      busy_d     = 1'b0;
      complete_d = 1'b0;
      aborted_d  = 1'b1;
      edge_d     = '0;
      dly_d      = '0;
    end else begin
      case (state_q)
        STATE_IDLE: begin
          if (w_start) begin
            ss_d       = w_sel_ss;
            busy_d     = 1'b1;
            complete_d = 1'b0;
            aborted_d  = 1'b0;
            valid_d    = 1'b1;
            n_d        = w_eff_n;
            edge_d     = '0;
            dly_d      = '0;
            // With CPHA=0 the first data bit must be on the line before edge 1.
            shift_d    = (sclk_phase == CPHA_SAMPLE_LEADING);
            state_d    = (tick_count_sclk_delay_leading == 0) ? STATE_CLOCK : STATE_LEAD;
          end
        end
        STATE_LEAD: begin
          if (dly_q == c_lead_last) begin
            dly_d   = '0;
            state_d = STATE_CLOCK;
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
        STATE_CLOCK: begin
          if (w_half) begin
            if (edge_q == w_two_n) begin
              // One extra half-period after the last edge before leaving.
              if (tick_count_sclk_delay_trailing == 0) begin
                w_release = 1'b1;
              end else begin
                dly_d   = '0;
                state_d = STATE_TRAIL;
              end
            end else begin
              sclk_d = !sclk_q;
              edge_d = edge_q + 1'b1;
              if (sclk_phase == CPHA_SAMPLE_LEADING) begin
                sample_d = w_leading;
                shift_d  = !w_leading && (edge_q != w_two_n_m1);
              end else begin
                shift_d  = w_leading;
                sample_d = !w_leading;
              end
            end
          end
        end
        STATE_TRAIL: begin
          if (dly_q == c_trail_last) begin
            w_release = 1'b1;
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
        STATE_DONE: begin
          if (dly_q == c_done_last) begin
            dly_d      = '0;
            complete_d = w_valid_live;
            busy_d     = 1'b0;
            state_d    = STATE_IDLE;
          end else begin
            dly_d = dly_q + 1'b1;
          end
        end
        default: begin
          state_d = STATE_IDLE;
        end
      endcase

      if (w_release) begin
        ss_d  = c_ss_idle;
        dly_d = '0;
        if (tick_count_complete_delay_trailing == 0) begin
          complete_d = w_valid_live;
          busy_d     = 1'b0;
          state_d    = STATE_IDLE;
        end else begin
          state_d = STATE_DONE;
        end
      end
    end

    if (invalidate) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= STATE_IDLE;
      trig_prev_q <= 1'b0;
      ss_q        <= c_ss_idle;
      sclk_q      <= sclk_polarity;
      shift_q     <= 1'b0;
      sample_q    <= 1'b0;
      busy_q      <= 1'b0;
      complete_q  <= 1'b0;
      aborted_q   <= 1'b0;
      valid_q     <= 1'b0;
      n_q         <= '0;
      edge_q      <= '0;
      dly_q       <= '0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= trig_prev_d;
      ss_q        <= ss_d;
      sclk_q      <= sclk_d;
      shift_q     <= shift_d;
      sample_q    <= sample_d;
      busy_q      <= busy_d;
      complete_q  <= complete_d;
      aborted_q   <= aborted_d;
      valid_q     <= valid_d;
      n_q         <= n_d;
      edge_q      <= edge_d;
      dly_q       <= dly_d;
    end
  end

  assign ss            = ss_q;
  assign sclk          = sclk_q;
  assign shift_strobe  = shift_q;
  assign sample_strobe = sample_q;
  assign busy          = busy_q;
  assign complete      = complete_q;
  assign aborted       = aborted_q;
  assign valid         = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_stimulus_multichannel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_stimulus_multichannel: directed bench for the SPI sequencer       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_spi_stimulus_multichannel;
  import spi_stimulus_multichannel_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic       trigger0, abort0, invalidate0;
  logic [1:0] channel0;
  logic [5:0] bitcount0;
  logic [3:0] ss0;
  logic       sclk0, shift0, sample0, busy0, complete0, aborted0, valid0;

  logic       trigger1, abort1, invalidate1;
  logic [2:0] channel1;
  logic [5:0] bitcount1;
  logic [4:0] ss1;
  logic       sclk1, shift1, sample1, busy1, complete1, aborted1, valid1;

  // Instance 0: default configuration (CPOL=0, CPHA=0, D=2, no delays).
  spi_stimulus_multichannel #(
    .channel_count(4), .max_bitcount(32), .clock_divider(2),
    .ss_polarity(1'b0), .sclk_polarity(CPOL_IDLE_LOW), .sclk_phase(CPHA_SAMPLE_LEADING),
    .tick_count_sclk_delay_leading(0), .tick_count_sclk_delay_trailing(0),
    .tick_count_complete_delay_trailing(0)
  ) dut0 (
    .clock(clock), .reset_n(reset_n), .trigger(trigger0), .channel(channel0),
    .bitcount(bitcount0), .abort(abort0), .invalidate(invalidate0), .ss(ss0),
    .sclk(sclk0), .shift_strobe(shift0), .sample_strobe(sample0), .busy(busy0),
    .complete(complete0), .aborted(aborted0), .valid(valid0)
  );

  // Instance 1: CPOL=1, CPHA=1, active-high SS, D=1, all delays non-zero.
  spi_stimulus_multichannel #(
    .channel_count(5), .max_bitcount(32), .clock_divider(1),
    .ss_polarity(1'b1), .sclk_polarity(CPOL_IDLE_HIGH), .sclk_phase(CPHA_SAMPLE_TRAILING),
    .tick_count_sclk_delay_leading(2), .tick_count_sclk_delay_trailing(1),
    .tick_count_complete_delay_trailing(2)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .trigger(trigger1), .channel(channel1),
    .bitcount(bitcount1), .abort(abort1), .invalidate(invalidate1), .ss(ss1),
    .sclk(sclk1), .shift_strobe(shift1), .sample_strobe(sample1), .busy(busy1),
    .complete(complete1), .aborted(aborted1), .valid(valid1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
  endtask

  int   t;
  int   edges, shifts, samples, first_edge, last_edge;
  int   ss_off, cpl_on, busy_off, bad_strobe, bad_ss;
  logic prev_sclk;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_rec();
    edges = 0; shifts = 0; samples = 0; first_edge = -1; last_edge = -1;
    ss_off = -1; cpl_on = -1; busy_off = -1; bad_strobe = 0; bad_ss = 0;
  endtask

  // Pulse trigger for one tick; afterwards the bench stands at tick T+1.
  task automatic start(input bit which);
    clear_rec();
    if (which) trigger1 = 1'b1; else trigger0 = 1'b1;
    tick();
    t = 1;
    trigger0 = 1'b0;
    trigger1 = 1'b0;
    prev_sclk = which ? sclk1 : sclk0;
  endtask

  // Advance to tick `upto`, recording edges, strobes and SS/flag transitions.
  task automatic watch(input bit which, input int upto,
                       input logic [4:0] exp_ss, input logic [4:0] idle_ss);
    logic       s, sh, sa, cp, bz, e;
    logic [4:0] sv;
    while (t < upto) begin
      tick();
      t++;
      s  = which ? sclk1   : sclk0;
      sh = which ? shift1  : shift0;
      sa = which ? sample1 : sample0;
      cp = which ? complete1 : complete0;
      bz = which ? busy1   : busy0;
      sv = which ? ss1     : {1'b0, ss0};
      e  = (s !== prev_sclk);
      prev_sclk = s;
      if (e) begin
        edges++;
        if (first_edge < 0) first_edge = t;
        last_edge = t;
      end
      if (sh) begin shifts++;  if (!e || s !== 1'b0) bad_strobe++; end
      if (sa) begin samples++; if (!e || s !== 1'b1) bad_strobe++; end
      if (sv == idle_ss) begin
        if (ss_off < 0) ss_off = t;
      end else if (sv != exp_ss || ss_off >= 0) begin
        bad_ss++;
      end
      if (cp && cpl_on < 0) cpl_on = t;
      if (!bz && busy_off < 0) busy_off = t;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    trigger0 = 1'b0; abort0 = 1'b0; invalidate0 = 1'b0; channel0 = '0; bitcount0 = '0;
    trigger1 = 1'b0; abort1 = 1'b0; invalidate1 = 1'b0; channel1 = '0; bitcount1 = '0;
    t = 0;
    clear_rec();
    repeat (2) tick();
    check("rst_ss0", ss0, 4'b1111);
    check("rst_sclk0", sclk0, 1'b0);
    check("rst_flags0", {busy0, complete0, aborted0, valid0, shift0, sample0}, 6'b0);
    check("rst_ss1", ss1, 5'b00000);
    check("rst_sclk1", sclk1, 1'b1);
    reset_n = 1'b1;
    repeat (2) tick();

    // Normal transfer: channel 2, 8 bits, D=2.
    channel0 = 2'd2; bitcount0 = 6'd8;
    start(1'b0);
    check("norm_ss_t1", ss0, 4'b1011);
    check("norm_busy_t1", busy0, 1'b1);
    check("norm_shift_t1", shift0, 1'b1);
    check("norm_flags_t1", {complete0, aborted0, valid0}, 3'b001);
    watch(1'b0, 40, 5'b01011, 5'b01111);
    check("norm_edges", edges, 16);
    check("norm_first_edge", first_edge, 3);
    check("norm_last_edge", last_edge, 33);
    check("norm_samples", samples, 8);
    check("norm_shifts", shifts, 7);
    check("norm_bad_strobe", bad_strobe, 0);
    check("norm_bad_ss", bad_ss, 0);
    check("norm_ss_off", ss_off, 35);
    check("norm_cpl_on", cpl_on, 35);
    check("norm_busy_off", busy_off, 35);
    check("norm_valid", valid0, 1'b1);

    // Second trigger while busy must not disturb the running transfer.
    channel0 = 2'd1; bitcount0 = 6'd2;
    start(1'b0);
    watch(1'b0, 4, 5'b01101, 5'b01111);
    channel0 = 2'd0; bitcount0 = 6'd5; trigger0 = 1'b1;
    watch(1'b0, 5, 5'b01101, 5'b01111);
    trigger0 = 1'b0;
    watch(1'b0, 16, 5'b01101, 5'b01111);
    check("busy_edges", edges, 4);
    check("busy_last_edge", last_edge, 9);
    check("busy_ss_off", ss_off, 11);
    check("busy_cpl_on", cpl_on, 11);
    check("busy_bad_ss", bad_ss, 0);

    // Invalidate mid-transfer: runs to the end but never completes.
    channel0 = 2'd0; bitcount0 = 6'd3;
    start(1'b0);
    watch(1'b0, 3, 5'b01110, 5'b01111);
    invalidate0 = 1'b1;
    watch(1'b0, 4, 5'b01110, 5'b01111);
    invalidate0 = 1'b0;
    check("inv_valid_now", valid0, 1'b0);
    watch(1'b0, 20, 5'b01110, 5'b01111);
    check("inv_edges", edges, 6);
    check("inv_ss_off", ss_off, 15);
    check("inv_busy_off", busy_off, 15);
    check("inv_no_complete", cpl_on, -1);
    check("inv_valid_end", valid0, 1'b0);

    // Abort on edge 5 together with a fresh trigger edge.
    channel0 = 2'd3; bitcount0 = 6'd8;
    start(1'b0);
    watch(1'b0, 11, 5'b00111, 5'b01111);
    check("abt_edges_before", edges, 5);
    check("abt_sclk_before", sclk0, 1'b1);
    abort0 = 1'b1; trigger0 = 1'b1;
    watch(1'b0, 12, 5'b00111, 5'b01111);
    abort0 = 1'b0;
    check("abt_ss", ss0, 4'b1111);
    check("abt_sclk", sclk0, 1'b0);
    check("abt_flags", {aborted0, busy0, complete0, shift0, sample0}, 5'b10000);
    watch(1'b0, 18, 5'b00111, 5'b01111);
    trigger0 = 1'b0;
    check("abt_no_restart", {busy0, ss0}, 5'b01111);

    // Rejected start: channel equal to channel_count.
    channel1 = 3'd5; bitcount1 = 6'd4;
    start(1'b1);
    check("rej_ss_t1", ss1, 5'b00000);
    check("rej_busy_t1", busy1, 1'b0);
    watch(1'b1, 10, 5'b00000, 5'b00000);
    check("rej_edges", edges, 0);
    check("rej_bad_ss", bad_ss, 0);

    // CPOL=1/CPHA=1, bitcount 0 -> full 32-bit transfer with all delays.
    channel1 = 3'd4; bitcount1 = 6'd0;
    start(1'b1);
    check("m3_ss_t1", ss1, 5'b10000);
    check("m3_busy_t1", busy1, 1'b1);
    check("m3_shift_t1", shift1, 1'b0);
    check("m3_sclk_t1", sclk1, 1'b1);
    watch(1'b1, 80, 5'b10000, 5'b00000);
    check("m3_edges", edges, 64);
    check("m3_first_edge", first_edge, 4);
    check("m3_last_edge", last_edge, 67);
    check("m3_shifts", shifts, 32);
    check("m3_samples", samples, 32);
    check("m3_bad_strobe", bad_strobe, 0);
    check("m3_bad_ss", bad_ss, 0);
    check("m3_ss_off", ss_off, 69);
    check("m3_cpl_on", cpl_on, 71);
    check("m3_busy_off", busy_off, 71);
    check("m3_sclk_idle", sclk1, 1'b1);

    // Over-range bitcount clamps to max_bitcount.
    channel1 = 3'd0; bitcount1 = 6'd63;
    start(1'b1);
    watch(1'b1, 80, 5'b00001, 5'b00000);
    check("clamp_edges", edges, 64);
    check("clamp_last_edge", last_edge, 67);
    check("clamp_cpl_on", cpl_on, 71);

    // Asynchronous reset in the middle of a transfer.
    channel0 = 2'd0; bitcount0 = 6'd4;
    start(1'b0);
    watch(1'b0, 6, 5'b01110, 5'b01111);
    check("arst_busy_before", busy0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ss0", ss0, 4'b1111);
    check("arst_sclk0", sclk0, 1'b0);
    check("arst_flags0", {busy0, complete0, aborted0, valid0, shift0, sample0}, 6'b0);
    check("arst_ss1", ss1, 5'b00000);
    check("arst_sclk1", sclk1, 1'b1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
